alu_uart_interface: RTL and testbench
=====================================

# alu_uart_interface

Sequencing stage between the UART receiver/transmitter and the `alu` block. It collects three received bytes (operand A, operand B, opcode) and drives them as registered ALU inputs. It then captures the ALU result and flags, and returns two bytes (result, then flags) through the UART transmitter handshake. A per-byte inactivity timeout discards partially received frames.

## Interface
- `DATA_WIDTH`, 8, UART byte width and ALU operand width; must be ≥ 3.
- `OP_WIDTH`, 6, ALU opcode width; must be ≤ `DATA_WIDTH`.
- `TIMEOUT_CYCLES`, 1000000, idle cycles tolerated between bytes of one frame; 0 disables the timeout.

Ports:
- `i_clk` input 1: single clock; all state changes on its rising edge.
- `i_rst_n` input 1: reset, asynchronous and active-low.
- `i_rx_data` input `DATA_WIDTH`: received byte; valid only when `i_rx_done`=1.
- `i_rx_done` input 1: one-cycle strobe, one byte received.
- `o_alu_a` output `DATA_WIDTH`: ALU operand A, registered.
- `o_alu_b` output `DATA_WIDTH`: ALU operand B, registered.
- `o_alu_op` output `OP_WIDTH`: ALU opcode, registered.
- `i_alu_result` input `DATA_WIDTH`: ALU result (combinational from `o_alu_*`).
- `i_alu_negative`, `i_alu_zero`, `i_alu_carry` input 1 each: ALU flags.
- `o_tx_data` output `DATA_WIDTH`: byte to transmit.
- `o_tx_start` output 1: one-cycle strobe requesting transmission of `o_tx_data`.
- `i_tx_done` input 1: one-cycle strobe, transmitter finished a byte.
- `o_busy` output 1: high in every state except `WAIT_A`.
- `o_timeout` output 1: one-cycle strobe when a partial frame is discarded.

## Operation
- FSM states: `WAIT_A`, `WAIT_B`, `WAIT_OP`, `EXEC`, `SEND_RES`, `WAIT_RES`, `SEND_FLG`, `WAIT_FLG`.
- `WAIT_A`:
  - On `i_rx_done`: `o_alu_a` ← `i_rx_data`; go to `WAIT_B`.
  - No timeout in this state.
- `WAIT_B`: on `i_rx_done`: `o_alu_b` ← `i_rx_data`; go to `WAIT_OP`.
- `WAIT_OP`: on `i_rx_done`: `o_alu_op` ← `i_rx_data[OP_WIDTH-1:0]` (upper bits dropped); go to `EXEC`.
- `EXEC`: one cycle; at its closing edge:
  - result register ← `i_alu_result`.
  - flags register ← {zeros, `i_alu_negative`, `i_alu_zero`, `i_alu_carry`} (bit2=N, bit1=Z, bit0=C).
  - Go to `SEND_RES`.
- `SEND_RES`:
  - `o_tx_data` = result, `o_tx_start`=1 for exactly this cycle.
  - Go to `WAIT_RES`.
- `WAIT_RES`: hold `o_tx_data`; on `i_tx_done` go to `SEND_FLG`.
- `SEND_FLG`:
  - `o_tx_data` = flags byte, `o_tx_start`=1 for this cycle.
  - Go to `WAIT_FLG`.
- `WAIT_FLG`: on `i_tx_done` go to `WAIT_A`.
- `i_rx_done` in `EXEC`/`SEND_*`/`WAIT_RES`/`WAIT_FLG` is ignored; the byte is lost.
- `i_tx_done` outside `WAIT_RES`/`WAIT_FLG` is ignored.
- Timeout:
  - Counter clears on entry to `WAIT_B`/`WAIT_OP` and increments each cycle in those states.
  - If it reaches `TIMEOUT_CYCLES`-1 with no `i_rx_done`: `o_timeout`=1 next cycle, state → `WAIT_A`, `o_alu_*` keep last values.
  - If `i_rx_done` arrives in the same cycle the count hits its limit, the byte wins (accepted, no timeout).
  - Counter width is $clog2(`TIMEOUT_CYCLES`+1).
- `o_alu_*` hold their values after the frame until overwritten by the next frame.

## Timing
- Reset (asynchronous, immediate) sets:
  - State `WAIT_A`, counter 0.
  - `o_alu_a`, `o_alu_b`, `o_alu_op`, `o_tx_data` = 0.
  - `o_tx_start`, `o_busy`, `o_timeout` = 0.
  - Result and flags registers = 0.
- Reset mid-frame or mid-transmission aborts without a further `o_tx_start`.
- Byte accepted at edge k (strobe in cycle k-1): the matching `o_alu_*` changes after edge k.
- Opcode accepted at edge k:
  - `EXEC` during cycle k..k+1; capture at edge k+1.
  - `o_tx_start` high during cycle k+1..k+2.
- Flags `o_tx_start`: exactly one cycle after the edge that samples `i_tx_done` in `WAIT_RES`.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Rx 0x05, 0x03, 0x20 → `o_alu_a`=0x05, `o_alu_b`=0x03, `o_alu_op`=0x20; with ALU attached, tx bytes 0x08 then 0x00; `o_busy` low after second `i_tx_done`.
- Rx 0xFF, 0x01, 0x20 (ADD) → tx 0x00 then flags 0x03 (Z=1, C=1).
- Rx 0x03, 0x05, 0x22 (SUB) → tx 0xFE then flags 0x04 (N=1, C=0 on borrow).
- `TIMEOUT_CYCLES`=16:
  - Rx 0x11, then idle 16 cycles → one `o_timeout` pulse, state `WAIT_A`.
  - Then rx 0x02, 0x02, 0x24 → tx 0x02, flags 0x00.
- Rx strobe 0x55 injected during `WAIT_RES` → ignored; next frame 0x01, 0x01, 0x20 yields 0x02.
- Assert `i_rst_n`=0 during `WAIT_FLG` → all outputs 0 immediately, no further `o_tx_start`.

Source files
------------

// File: rtl/alu_uart_interface_if.sv
// Byte bus between the UART/ALU sequencer (slave) and its UART and ALU neighbours (master).
// Carries rx/tx strobes, ALU operands/opcode and ALU result/flags.
interface alu_uart_interface_if #(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 6
);
  logic [DATA_WIDTH-1:0] i_rx_data;
  logic                  i_rx_done;
  logic [DATA_WIDTH-1:0] o_alu_a;
  logic [DATA_WIDTH-1:0] o_alu_b;
  logic [OP_WIDTH-1:0]   o_alu_op;
  logic [DATA_WIDTH-1:0] i_alu_result;
  logic                  i_alu_negative;
  logic                  i_alu_zero;
  logic                  i_alu_carry;
  logic [DATA_WIDTH-1:0] o_tx_data;
  logic                  o_tx_start;
  logic                  i_tx_done;
  logic                  o_busy;
  logic                  o_timeout;

  modport slave (
    input  i_rx_data, i_rx_done,
    input  i_alu_result, i_alu_negative, i_alu_zero, i_alu_carry,
    input  i_tx_done,
    output o_alu_a, o_alu_b, o_alu_op,
    output o_tx_data, o_tx_start, o_busy, o_timeout
  );

  modport master (
    output i_rx_data, i_rx_done,
    output i_alu_result, i_alu_negative, i_alu_zero, i_alu_carry,
    output i_tx_done,
    input  o_alu_a, o_alu_b, o_alu_op,
    input  o_tx_data, o_tx_start, o_busy, o_timeout
  );
endinterface

// File: rtl/alu_uart_interface.sv
// Collects A, B, opcode bytes from the UART, drives the ALU, returns result then flags bytes.
// Result tx_start one cycle after opcode accept; tx waits on i_tx_done; partial frames time out.
module alu_uart_interface #(
  parameter int DATA_WIDTH     = 8,
  parameter int OP_WIDTH       = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  alu_uart_interface_if.slave bus
);

  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : {CNT_W{1'b0}};

  typedef enum logic [2:0] {
    S_WAIT_A,
    S_WAIT_B,
    S_WAIT_OP,
    S_EXEC,
    S_SEND_RES,
    S_WAIT_RES,
    S_SEND_FLG,
    S_WAIT_FLG
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [OP_WIDTH-1:0]   r_alu_op;
  logic [DATA_WIDTH-1:0] r_flags;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_start;
  logic                  r_busy;
  logic                  r_timeout;

  logic w_rx_wait;
  logic w_cnt_hit;
  logic w_timeout;
  logic w_load_a;
  logic w_load_b;
  logic w_load_op;

  // Only the mid-frame states are guarded; a byte arriving on the limit cycle still wins.
  assign w_rx_wait = (r_state == S_WAIT_B) || (r_state == S_WAIT_OP);
  assign w_cnt_hit = TO_EN && w_rx_wait && (r_cnt == CNT_LIMIT);
  assign w_timeout = w_cnt_hit && !bus.i_rx_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_WAIT_A;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_load_a  = 1'b0;
    w_load_b  = 1'b0;
    w_load_op = 1'b0;
    case (r_state)
      S_WAIT_A: begin
        if (bus.i_rx_done) begin
          w_load_a = 1'b1;
          w_next   = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (bus.i_rx_done) begin
          w_load_b = 1'b1;
          w_next   = S_WAIT_OP;
        end else if (w_cnt_hit) begin
          w_next = S_WAIT_A;
        end
      end
      S_WAIT_OP: begin
        if (bus.i_rx_done) begin
          w_load_op = 1'b1;
          w_next    = S_EXEC;
        end else if (w_cnt_hit) begin
          w_next = S_WAIT_A;
        end
      end
      S_EXEC:     w_next = S_SEND_RES;
      S_SEND_RES: w_next = S_WAIT_RES;
      S_WAIT_RES: if (bus.i_tx_done) w_next = S_SEND_FLG;
      S_SEND_FLG: w_next = S_WAIT_FLG;
      S_WAIT_FLG: if (bus.i_tx_done) w_next = S_WAIT_A;
      default:    w_next = S_WAIT_A;
    endcase
  end

  // Any state change restarts the count, so entry to WAIT_B/WAIT_OP always starts at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (TO_EN && w_rx_wait) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= '0;
    end else begin
      if (w_load_a)  r_alu_a  <= bus.i_rx_data;
      if (w_load_b)  r_alu_b  <= bus.i_rx_data;
      if (w_load_op) r_alu_op <= bus.i_rx_data[OP_WIDTH-1:0];
    end
  end

  // r_tx_data doubles as the result register: it is loaded at the EXEC edge and held until flags go out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_flags   <= '0;
      r_tx_data <= '0;
    end else if (r_state == S_EXEC) begin
      r_flags   <= DATA_WIDTH'({bus.i_alu_negative, bus.i_alu_zero, bus.i_alu_carry});
      r_tx_data <= bus.i_alu_result;
    end else if ((r_state == S_WAIT_RES) && bus.i_tx_done) begin
      r_tx_data <= r_flags;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tx_start <= 1'b0;
      r_busy     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_tx_start <= (w_next == S_SEND_RES) || (w_next == S_SEND_FLG);
      r_busy     <= (w_next != S_WAIT_A);
      r_timeout  <= w_timeout;
    end
  end

  assign bus.o_alu_a    = r_alu_a;
  assign bus.o_alu_b    = r_alu_b;
  assign bus.o_alu_op   = r_alu_op;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_tx_start = r_tx_start;
  assign bus.o_busy     = r_busy;
  assign bus.o_timeout  = r_timeout;

endmodule

// File: tb/tb_alu_uart_interface.sv
// Randomized scoreboard bench for alu_uart_interface with a behavioural ALU and auto-responding UART tx.
module tb_alu_uart_interface;
  localparam int DW = 8;
  localparam int OW = 6;
  localparam int TO = 16;

  logic clk     = 1'b0;
  logic rst_n   = 1'b0;
  logic tx_hold = 1'b0;

  int total         = 0;
  int bad           = 0;
  int exp_timeouts  = 0;
  int seen_timeouts = 0;

  logic [7:0]  exp_tx_q[$];
  logic [21:0] exp_frame_q[$];
  logic        mon_phase = 1'b0;
  logic [10:0] alu_t;

  always #5 clk = ~clk;

  alu_uart_interface_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

  alu_uart_interface #(
    .DATA_WIDTH(DW),
    .OP_WIDTH(OW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  // Reference ALU: returns {N, Z, C, result}; carry on SUB means "no borrow".
  function automatic logic [10:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
    int unsigned ua, ub, r;
    logic        c;
    logic [7:0]  res;
    ua = 32'(a);
    ub = 32'(b);
    c  = 1'b0;
    case (op)
      6'h20: begin r = ua + ub; c = (r > 255); end
      6'h22: begin r = ua + 256 - ub; c = (ua >= ub); end
      6'h24: r = ua & ub;
      6'h25: r = ua | ub;
      6'h26: r = ua ^ ub;
      6'h27: r = ~(ua | ub);
      default: r = ua;
    endcase
    res = r[7:0];
    return {res[7], (res == 8'h00), c, res};
  endfunction

  assign alu_t              = alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);
  assign bus.i_alu_result   = alu_t[7:0];
  assign bus.i_alu_carry    = alu_t[8];
  assign bus.i_alu_zero     = alu_t[9];
  assign bus.i_alu_negative = alu_t[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] d);
    bus.i_rx_data = d;
    bus.i_rx_done = 1'b1;
    tick();
    bus.i_rx_done = 1'b0;
  endtask

  task automatic expect_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                              input logic [7:0] res, input logic [7:0] flg);
    exp_frame_q.push_back({a, b, opb[5:0]});
    exp_tx_q.push_back(res);
    exp_tx_q.push_back(flg);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (bus.o_busy && n < 300) begin
      tick();
      n++;
    end
    check(name, 32'(bus.o_busy), 32'd0);
  endtask

  task automatic wait_tx_start(input string name);
    int n = 0;
    while (!bus.o_tx_start && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(bus.o_tx_start), 32'd1);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb, input int gap,
                           input logic [7:0] res, input logic [7:0] flg, input string name);
    expect_frame(a, b, opb, res, flg);
    rx_byte(a);
    repeat (gap) tick();
    rx_byte(b);
    repeat (gap) tick();
    rx_byte(opb);
    wait_idle(name);
  endtask

  // Called just after the accepting edge of the last byte; the pulse is due 16 edges later.
  task automatic timeout_wait(input string name);
    int n = 0;
    while (!bus.o_timeout && n < 40) begin
      tick();
      n++;
    end
    check({name, "_cycles"}, 32'(n), 32'(TO));
    check({name, "_busy"}, 32'(bus.o_busy), 32'd0);
  endtask

  // UART transmitter model: finishes each requested byte after a random delay unless held.
  initial begin
    bus.i_tx_done = 1'b0;
    forever begin
      if (rst_n && bus.o_tx_start) begin
        repeat ($urandom_range(1, 4)) tick();
        if (!tx_hold) begin
          bus.i_tx_done = 1'b1;
          tick();
          bus.i_tx_done = 1'b0;
        end
      end else begin
        tick();
      end
    end
  end

  // Scoreboard monitor: every tx_start consumes one expected byte; the result byte also checks operands.
  initial begin
    logic [7:0]  e;
    logic [21:0] f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_phase = 1'b0;
      end else begin
        if (bus.o_timeout) seen_timeouts++;
        if (bus.o_tx_start) begin
          total++;
          if (exp_tx_q.size() == 0) begin
            bad++;
            $display("FAIL tx_unexpected: got start with data %0h expected no start", bus.o_tx_data);
          end else begin
            e = exp_tx_q.pop_front();
            if (bus.o_tx_data !== e) begin
              bad++;
              $display("FAIL tx_byte: got %0h expected %0h", bus.o_tx_data, e);
            end
          end
          if (!mon_phase) begin
            total++;
            if (exp_frame_q.size() == 0) begin
              bad++;
              $display("FAIL frame_unexpected: got operands %0h expected none", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op});
            end else begin
              f = exp_frame_q.pop_front();
              if ({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op} !== f) begin
                bad++;
                $display("FAIL frame_operands: got %0h expected %0h", {bus.o_alu_a, bus.o_alu_b, bus.o_alu_op}, f);
              end
            end
          end
          mon_phase = ~mon_phase;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  a, b, opb;
    logic [5:0]  ops[6];
    logic [10:0] t;
    int          gap;
    ops = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
    bus.i_rx_data = '0;
    bus.i_rx_done = 1'b0;

    repeat (3) tick();
    check("reset_alu", 32'({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op}), 32'd0);
    check("reset_tx", 32'({bus.o_tx_data, bus.o_tx_start, bus.o_busy, bus.o_timeout}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Frame 1 with per-byte latency checks
    expect_frame(8'h05, 8'h03, 8'h20, 8'h08, 8'h00);
    rx_byte(8'h05);
    check("accept_a", 32'(bus.o_alu_a), 32'h05);
    check("busy_after_a", 32'(bus.o_busy), 32'd1);
    rx_byte(8'h03);
    check("accept_b", 32'(bus.o_alu_b), 32'h03);
    rx_byte(8'h20);
    check("accept_op", 32'(bus.o_alu_op), 32'h20);
    check("no_start_in_exec", 32'(bus.o_tx_start), 32'd0);
    tick();
    check("start_after_exec", 32'(bus.o_tx_start), 32'd1);
    wait_idle("idle_frame1");

    run_frame(8'hFF, 8'h01, 8'h20, 0, 8'h00, 8'h03, "idle_add_wrap");
    run_frame(8'h03, 8'h05, 8'h22, 2, 8'hFE, 8'h04, "idle_sub_borrow");
    run_frame(8'h0F, 8'h3C, 8'hE4, 1, 8'h0C, 8'h00, "idle_and_upper_op");
    check("op_upper_dropped", 32'(bus.o_alu_op), 32'h24);

    // Timeout in WAIT_B: operands B/op keep previous values
    rx_byte(8'h11);
    check("to_b_accept_a", 32'(bus.o_alu_a), 32'h11);
    timeout_wait("to_wait_b");
    exp_timeouts++;
    check("to_b_keep_b_op", 32'({bus.o_alu_b, bus.o_alu_op}), 32'({8'h3C, 6'h24}));
    tick();
    check("to_b_single_pulse", 32'(bus.o_timeout), 32'd0);
    run_frame(8'h02, 8'h02, 8'h24, 0, 8'h02, 8'h00, "idle_after_to");

    // Timeout in WAIT_OP
    rx_byte(8'h40);
    rx_byte(8'h41);
    timeout_wait("to_wait_op");
    exp_timeouts++;
    tick();

    // Byte arriving on the limit cycle is accepted
    run_frame(8'h7F, 8'h01, 8'h20, TO - 1, 8'h80, 8'h04, "idle_gap_limit");

    // Rx strobe during WAIT_RES is dropped
    expect_frame(8'h10, 8'h20, 8'h20, 8'h30, 8'h00);
    rx_byte(8'h10);
    rx_byte(8'h20);
    rx_byte(8'h20);
    wait_tx_start("inject_res_start");
    tick();
    rx_byte(8'h55);
    wait_idle("idle_inject");
    check("inject_a_kept", 32'(bus.o_alu_a), 32'h10);
    run_frame(8'h01, 8'h01, 8'h20, 0, 8'h02, 8'h00, "idle_after_inject");

    for (int i = 0; i < 40; i++) begin
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255));
      opb = {2'($urandom_range(0, 3)), ops[$urandom_range(0, 5)]};
      gap = $urandom_range(0, TO - 1);
      if ($urandom_range(0, 5) == 0) begin
        rx_byte(a);
        if ($urandom_range(0, 1) == 1) begin
          repeat (gap) tick();
          rx_byte(b);
        end
        repeat (TO + 1) tick();
        exp_timeouts++;
        check("rand_to_idle", 32'(bus.o_busy), 32'd0);
      end else begin
        t = alu_ref(a, b, opb[5:0]);
        run_frame(a, b, opb, gap, t[7:0], {5'b0, t[10:8]}, "rand_idle");
      end
      repeat ($urandom_range(0, 3)) tick();
    end

    // Reset while waiting for the flags byte to finish
    expect_frame(8'h33, 8'h11, 8'h22, 8'h22, 8'h01);
    rx_byte(8'h33);
    rx_byte(8'h11);
    rx_byte(8'h22);
    wait_tx_start("rst_res_start");
    tick();
    wait_tx_start("rst_flg_start");
    tx_hold = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_alu", 32'({bus.o_alu_a, bus.o_alu_b, bus.o_alu_op}), 32'd0);
    check("rst_async_tx", 32'({bus.o_tx_data, bus.o_tx_start, bus.o_busy, bus.o_timeout}), 32'd0);
    tick();
    tick();
    rst_n   = 1'b1;
    tx_hold = 1'b0;
    repeat (20) tick();
    check("rst_stays_idle", 32'(bus.o_busy), 32'd0);

    check("timeout_count", 32'(seen_timeouts), 32'(exp_timeouts));
    check("tx_queue_drained", 32'(exp_tx_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
